// File: rtl/phase_decim.sv
// phase_decim: decimating averager for signed phase-error samples.
// Sums blocks of 2^N valid samples and emits the arithmetically shifted mean
// with a one-cycle strobe. It also counts the emitted blocks.
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   en           - enable; low returns to IDLE and drops the partial block
//   decim_log2   - requested block exponent N, clamped to MAX_LOG2
//   sample_in    - signed input sample, qualified by sample_vld
//   data_ns      - sign-extended block mean, held between strobes
//   data_vld     - one-cycle strobe marking a new data_ns
//   blk_cnt      - count of emitted blocks (wraps)
//   busy         - in ACCUM with a partial block started
module phase_decim #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOG2   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [3:0]                   decim_log2,
  input  logic signed [IN_WIDTH-1:0]   sample_in,
  input  logic                         sample_vld,
  output logic [DATA_WIDTH-1:0]        data_ns,
  output logic                         data_vld,
  output logic [31:0]                  blk_cnt,
  output logic                         busy
);

  localparam int unsigned ACC_W = IN_WIDTH + MAX_LOG2;
  localparam int unsigned CNT_W = MAX_LOG2 + 1;
  localparam int unsigned N_W   = $clog2(MAX_LOG2 + 1);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_W-1:0]            n_q, n_d;
  logic [DATA_WIDTH-1:0]     data_d;
  logic                      vld_d;
  logic [31:0]               blk_d;
  logic                      busy_d;

  logic [31:0]               req_ext;
  logic [N_W-1:0]            n_req;
  logic [CNT_W-1:0]          last_idx;
  logic signed [ACC_W-1:0]   sum;
  logic signed [IN_WIDTH-1:0] mean;

  // Clamped exponent, index of the last sample in a block, running sum and mean
  always_comb begin
    req_ext  = 32'(decim_log2);
    n_req    = (req_ext > MAX_LOG2) ? N_W'(MAX_LOG2) : N_W'(req_ext);
    last_idx = CNT_W'((32'd1 << n_q) - 32'd1);
    sum      = acc_q + ACC_W'(sample_in);
    // Mean of 2^N values of IN_WIDTH bits always fits back in IN_WIDTH bits
    mean     = IN_WIDTH'(sum >>> n_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    data_d  = data_ns;
    vld_d   = 1'b0;
    blk_d   = blk_cnt;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) begin
          n_d     = n_req;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!en) begin
          // Partial block (including a completing sample this cycle) is dropped
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_vld) begin
          if (cnt_q == last_idx) begin
            vld_d  = 1'b1;
            data_d = DATA_WIDTH'(mean);
            blk_d  = blk_cnt + 32'd1;
            acc_d  = '0;
            cnt_d  = '0;
            // Block boundary is the only point where N may change
            n_d    = n_req;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM) && (cnt_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      data_ns  <= '0;
      data_vld <= 1'b0;
      blk_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      data_ns  <= data_d;
      data_vld <= vld_d;
      blk_cnt  <= blk_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_phase_decim.sv
// tb_phase_decim: directed self-checking bench for phase_decim.
module tb_phase_decim;

  logic               clk;
  logic               rst;
  logic               en;
  logic [3:0]         decim_log2;
  logic signed [15:0] sample_in;
  logic               sample_vld;
  logic [31:0]        data_ns;
  logic               data_vld;
  logic [31:0]        blk_cnt;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_blk = 32'd0;

  phase_decim dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .decim_log2 (decim_log2),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .data_ns    (data_ns),
    .data_vld   (data_vld),
    .blk_cnt    (blk_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are observed 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v, input logic vld);
    sample_in  = v;
    sample_vld = vld;
    cyc();
  endtask

  // Drop to IDLE for one cycle, then enable with a new exponent
  task automatic start(input logic [3:0] n);
    en = 1'b0; sample_vld = 1'b0;
    cyc();
    decim_log2 = n; en = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; decim_log2 = 4'd0; sample_in = 16'sd7; sample_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_vld = ~sample_vld;
      cyc();
      n_cmp++; if (data_ns !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_ns); end
      n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", data_vld); end
      n_cmp++; if (blk_cnt !== 32'd0) begin n_err++; $display("FAIL reset_blk: got %h want 0", blk_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    rst = 1'b0; sample_vld = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    start(4'd2);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy0: got %b want 0", busy); end
    send(16'sd4, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy1: got %b want 1", busy); end
    send(16'sd8, 1'b1);
    send(16'sd12, 1'b1);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_vld: got %b want 0", data_vld); end
    send(16'sd16, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'd10) begin n_err++; $display("FAIL basic_data: got %h want %h", data_ns, 32'd10); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL basic_blk: got %h want %h", blk_cnt, exp_blk); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    send(16'sd0, 1'b0);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width: got %b want 0", data_vld); end
    n_cmp++; if (data_ns !== 32'd10) begin n_err++; $display("FAIL basic_hold: got %h want %h", data_ns, 32'd10); end
  endtask

  task automatic test_neg_gap();
    start(4'd1);
    send(-16'sd3, 1'b1);
    send(16'sd0, 1'b0);
    send(16'sd0, 1'b0);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL neg_gap_vld: got %b want 0", data_vld); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL neg_gap_busy: got %b want 1", busy); end
    send(16'sd0, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL neg_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL neg_data: got %h want FFFFFFFE", data_ns); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL neg_blk: got %h want %h", blk_cnt, exp_blk); end
  endtask

  task automatic test_stream_clamp();
    start(4'd0);
    for (int i = 1; i <= 5; i++) begin
      send(16'(i), 1'b1);
      exp_blk = exp_blk + 32'd1;
      n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL stream_vld[%0d]: got %b want 1", i, data_vld); end
      n_cmp++; if (data_ns !== 32'(i)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, data_ns, 32'(i)); end
    end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL stream_blk: got %h want %h", blk_cnt, exp_blk); end
    start(4'd15);
    for (int i = 0; i < 255; i++) begin
      send(16'sh7FFF, 1'b1);
      n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL clamp_early_vld[%0d]: got %b want 0", i, data_vld); end
    end
    send(16'sh7FFF, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL clamp_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'd32767) begin n_err++; $display("FAIL clamp_data: got %h want %h", data_ns, 32'd32767); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL clamp_blk: got %h want %h", blk_cnt, exp_blk); end
  endtask

  task automatic test_abort();
    start(4'd3);
    for (int i = 0; i < 5; i++) send(16'sd7, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", busy); end
    en = 1'b0;
    send(16'sd7, 1'b1);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL abort_vld: got %b want 0", data_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_off: got %b want 0", busy); end
    n_cmp++; if (data_ns !== 32'd32767) begin n_err++; $display("FAIL abort_hold: got %h want %h", data_ns, 32'd32767); end
    en = 1'b1;
    send(16'sd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(16'sd2, 1'b1);
      n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL abort_early_vld[%0d]: got %b want 0", i, data_vld); end
    end
    send(16'sd2, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL abort_vld2: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'd2) begin n_err++; $display("FAIL abort_data: got %h want %h", data_ns, 32'd2); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL abort_blk: got %h want %h", blk_cnt, exp_blk); end
    // Completing sample arriving together with en falling is dropped
    start(4'd1);
    send(16'sd5, 1'b1);
    en = 1'b0;
    send(16'sd5, 1'b1);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL abort_last_vld: got %b want 0", data_vld); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL abort_last_blk: got %h want %h", blk_cnt, exp_blk); end
  endtask

  task automatic test_cfg_wrap();
    start(4'd2);
    send(16'sd10, 1'b1);
    send(16'sd20, 1'b1);
    decim_log2 = 4'd1;
    send(16'sd30, 1'b1);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL cfg_mid_vld: got %b want 0", data_vld); end
    send(16'sd40, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL cfg_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'd25) begin n_err++; $display("FAIL cfg_data: got %h want %h", data_ns, 32'd25); end
    send(16'sd6, 1'b1);
    n_cmp++; if (data_vld !== 1'b0) begin n_err++; $display("FAIL cfg_new_mid_vld: got %b want 0", data_vld); end
    send(16'sd9, 1'b1);
    exp_blk = exp_blk + 32'd1;
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL cfg_new_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'd7) begin n_err++; $display("FAIL cfg_new_data: got %h want %h", data_ns, 32'd7); end
    n_cmp++; if (blk_cnt !== exp_blk) begin n_err++; $display("FAIL cfg_blk: got %h want %h", blk_cnt, exp_blk); end
    // Preload the block counter just below wrap
    force dut.blk_cnt = 32'hFFFF_FFFF;
    send(16'sd0, 1'b0);
    release dut.blk_cnt;
    n_cmp++; if (blk_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h want FFFFFFFF", blk_cnt); end
    send(-16'sd1, 1'b1);
    send(16'sd0, 1'b1);
    n_cmp++; if (data_vld !== 1'b1) begin n_err++; $display("FAIL wrap_vld: got %b want 1", data_vld); end
    n_cmp++; if (data_ns !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_data: got %h want FFFFFFFF", data_ns); end
    n_cmp++; if (blk_cnt !== 32'd0) begin n_err++; $display("FAIL wrap_blk: got %h want 0", blk_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_gap();
    test_stream_clamp();
    test_abort();
    test_cfg_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
